param_reservation_station: RTL and testbench
============================================

// Module: param_reservation_station
// PURPOSE
//  Generic out-of-order reservation station: successor to the per-unit ALU/BU/FPU RS.
//  - Buffers renamed instructions until all N_SRC operands are valid, then issues one ready entry per cycle.
//  - Snoops N_WAKEUP writeback buses; the execution unit attaches at the issue port.
//  - Sits between rename/register-file dispatch and one execution unit.
// PARAMETERS
//  N_LINE     16  entries (>=2)
//  N_SRC      2   source operands per entry (1..3)
//  N_WAKEUP   2   writeback broadcast ports snooped per cycle
//  TAG_W      6   physical register tag width
//  DATA_W     32  operand data width
//  PAYLOAD_W  48  opaque instruction payload (opcode, dest, commit_id), passed through unchanged
// PORTS
//  clock          in   1                  system clock
//  reset_n        in   1                  synchronous active-low reset
//  flash          in   1                  pipeline flush (misprediction)
//  in_en          in   1                  dispatch valid
//  in_reject      out  1                  dispatch back-pressure (=full)
//  in_payload     in   PAYLOAD_W          instruction payload
//  in_src_valid   in   N_SRC              per-operand: 1=data present, 0=waiting on tag
//  in_src_tag     in   N_SRC*TAG_W        operand tags (used when valid=0)
//  in_src_data    in   N_SRC*DATA_W       operand data (used when valid=1)
//  wb_en          in   N_WAKEUP           writeback broadcast valid
//  wb_tag         in   N_WAKEUP*TAG_W     writeback dest_phys
//  wb_data        in   N_WAKEUP*DATA_W    writeback data
//  issue_en       out  1                  issue valid
//  issue_reject   in   1                  execution unit busy
//  issue_payload  out  PAYLOAD_W          selected entry payload
//  issue_src_data out  N_SRC*DATA_W       selected entry operands
//  count          out  $clog2(N_LINE+1)   occupied entries
// BEHAVIOUR
//  - Reset (reset_n=0 at posedge): all entries empty, count=0, age state cleared.
//    issue_en=0 and in_reject=0 from the following cycle. Reset overrides flash and all other inputs.
//  - Dispatch: accepted iff in_en & ~in_reject.
//    Written into the lowest-index empty entry at the posedge. in_reject = (count==N_LINE).
//    A same-cycle issue does NOT make room: accepting while full is never allowed.
//  - Dispatch snoop: an incoming operand with valid=0 whose tag matches an active wb port in the same cycle
//    is stored valid with that wb_data. No lost wakeup.
//  - Wakeup: for every occupied entry and operand with valid=0, a matching wb port sets valid=1 and
//    captures the data at the posedge. If several ports match, the lowest port index wins.
//    A woken entry is issuable the next cycle, not combinationally in the same cycle.
//  - Ready(i) = occupied(i) & all N_SRC operands valid.
//  - Issue is combinational from registered state, zero latency:
//    issue_en = |ready & ~flash; payload and data come from the selected entry.
//    The entry frees at the posedge iff issue_en & ~issue_reject.
//    While issue_reject=1, the selection may change between cycles; no entry is lost.
//  - Simultaneous dispatch + issue: both take effect. count += accept - issue.
//    A freed slot is reusable only from the next cycle.
//  - Flush: at the posedge with flash=1, all entries are emptied and count=0.
//    issue_en=0 during the flash cycle. Dispatch in the same cycle is discarded.
//  - count never exceeds N_LINE. Tag compare is exact TAG_W bits. Data is not modified.
// CONFIGURATION
//  RS_OLDEST_FIRST_EN defined:
//    - An N_LINE x N_LINE age matrix, updated on dispatch and free, selects the oldest ready entry (dispatch order).
//    - A dispatched entry is younger than all existing entries. The selection is unique.
//  RS_OLDEST_FIRST_EN undefined:
//    - A priority encoder selects the lowest-index ready entry.
//    - No age state is built. Order is by index only.
// TESTING
//  T1 reset: hold reset_n=0 2 cycles with in_en=1 -> count=0, issue_en=0 after release, no entry written.
//  T2 ready dispatch: src_valid=11, data 5/7, payload 0x0A1 -> issue_en=1 next cycle with data 5,7;
//     issue_reject=0 -> count returns to 0.
//  T3 wakeup: dispatch with src1 tag 9 waiting; wb_en[1]=1 tag 9 data 0x1234 two cycles later ->
//     issue_en=1 on the cycle after the broadcast, src1=0x1234.
//     Repeat with the broadcast in the dispatch cycle -> same result (snoop).
//  T4 full/back-pressure: issue_reject=1, dispatch 16 ready entries -> in_reject=1 at count=16;
//     extra in_en ignored. issue_reject=0 -> one entry drains per cycle.
//  T5 ordering: fill entries 3 (old) then 0 (new), both ready in the same cycle ->
//     with RS_OLDEST_FIRST_EN the entry-3 payload issues first; without it entry 0 issues first.
//  T6 flush: 5 entries plus a dispatch during flash=1 -> count=0 next cycle, issue_en=0 in the flash cycle,
//     the dispatched entry is absent, and a later wb of its tags has no effect.

Source files
------------

// File: rtl/param_reservation_station.sv
// param_reservation_station
//   Generic out-of-order reservation station. It holds renamed instructions until every source
//   operand is valid, then issues one ready entry per cycle to a single execution unit.
//   Writeback buses are snooped both for stored entries and for the instruction being dispatched.
//
// Ports
//   clock_i            system clock
//   reset_n_i          synchronous active-low reset (overrides everything)
//   flash_i            pipeline flush: empties the station and drops same-cycle dispatch
//   in_en_i            dispatch valid
//   in_reject_o        dispatch back-pressure (station full)
//   in_payload_i       opaque instruction payload
//   in_src_valid_i     per operand: 1 = data present, 0 = waiting on tag
//   in_src_tag_i       operand tags, operand k at [k*TAG_W +: TAG_W]
//   in_src_data_i      operand data, operand k at [k*DATA_W +: DATA_W]
//   wb_en_i            writeback broadcast valid per port
//   wb_tag_i           writeback destination tags
//   wb_data_i          writeback data
//   issue_en_o         issue valid
//   issue_reject_i     execution unit busy; the selected entry stays
//   issue_payload_o    payload of the selected entry
//   issue_src_data_o   operands of the selected entry
//   count_o            number of occupied entries
//
// Configuration
//   RS_OLDEST_FIRST_EN  defined: an age matrix selects the oldest ready entry.
//                       undefined: the lowest-index ready entry is selected.
module param_reservation_station #(
  parameter int unsigned N_LINE    = 16,
  parameter int unsigned N_SRC     = 2,
  parameter int unsigned N_WAKEUP  = 2,
  parameter int unsigned TAG_W     = 6,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned PAYLOAD_W = 48
) (
  input  logic                          clock_i,
  input  logic                          reset_n_i,
  input  logic                          flash_i,
  input  logic                          in_en_i,
  output logic                          in_reject_o,
  input  logic [PAYLOAD_W-1:0]          in_payload_i,
  input  logic [N_SRC-1:0]              in_src_valid_i,
  input  logic [N_SRC*TAG_W-1:0]        in_src_tag_i,
  input  logic [N_SRC*DATA_W-1:0]       in_src_data_i,
  input  logic [N_WAKEUP-1:0]           wb_en_i,
  input  logic [N_WAKEUP*TAG_W-1:0]     wb_tag_i,
  input  logic [N_WAKEUP*DATA_W-1:0]    wb_data_i,
  output logic                          issue_en_o,
  input  logic                          issue_reject_i,
  output logic [PAYLOAD_W-1:0]          issue_payload_o,
  output logic [N_SRC*DATA_W-1:0]       issue_src_data_o,
  output logic [$clog2(N_LINE+1)-1:0]   count_o
);

  localparam int unsigned IdxW = $clog2(N_LINE);
  localparam int unsigned CntW = $clog2(N_LINE + 1);

  logic [N_LINE-1:0]          occ_q, occ_d;
  logic [N_SRC-1:0]           vld_q  [N_LINE];
  logic [N_SRC-1:0]           vld_d  [N_LINE];
  logic [N_SRC*TAG_W-1:0]     tag_q  [N_LINE];
  logic [N_SRC*TAG_W-1:0]     tag_d  [N_LINE];
  logic [N_SRC*DATA_W-1:0]    data_q [N_LINE];
  logic [N_SRC*DATA_W-1:0]    data_d [N_LINE];
  logic [PAYLOAD_W-1:0]       pl_q   [N_LINE];
  logic [PAYLOAD_W-1:0]       pl_d   [N_LINE];
  logic [CntW-1:0]            count_q, count_d;

  logic [N_LINE-1:0]          ready;
  logic [IdxW-1:0]            sel_idx;
  logic [IdxW-1:0]            alloc_idx;
  logic                       accept;
  logic                       fire;
  logic [N_SRC-1:0]           in_vld;
  logic [N_SRC*DATA_W-1:0]    in_data;

  // Returns {hit, data}; the lowest-index matching port wins.
  function automatic logic [DATA_W:0] snoop(input logic [TAG_W-1:0]          tag,
                                            input logic [N_WAKEUP-1:0]       en,
                                            input logic [N_WAKEUP*TAG_W-1:0] tags,
                                            input logic [N_WAKEUP*DATA_W-1:0] datas);
    logic [DATA_W:0] res;
    res = '0;
    for (int w = int'(N_WAKEUP) - 1; w >= 0; w--) begin
      if (en[w] && (tags[w*TAG_W +: TAG_W] == tag)) begin
        res = {1'b1, datas[w*DATA_W +: DATA_W]};
      end
    end
    return res;
  endfunction

  assign in_reject_o = (count_q == CntW'(N_LINE));
  assign accept      = in_en_i & ~in_reject_o & ~flash_i;
  assign issue_en_o  = (|ready) & ~flash_i;
  assign fire        = issue_en_o & ~issue_reject_i;
  assign count_o     = count_q;

  assign issue_payload_o  = pl_q[sel_idx];
  assign issue_src_data_o = data_q[sel_idx];

  always_comb begin
    for (int i = 0; i < int'(N_LINE); i++) begin
      ready[i] = occ_q[i] & (&vld_q[i]);
    end
  end

  // Allocation looks at registered occupancy only, so a slot freed this cycle is not reused.
  always_comb begin
    alloc_idx = '0;
    for (int i = int'(N_LINE) - 1; i >= 0; i--) begin
      if (!occ_q[i]) alloc_idx = IdxW'(i);
    end
  end

  // Dispatch-cycle snoop so a broadcast coinciding with dispatch is not lost.
  always_comb begin
    logic [DATA_W:0] hit;
    in_vld  = in_src_valid_i;
    in_data = in_src_data_i;
    for (int k = 0; k < int'(N_SRC); k++) begin
      hit = snoop(in_src_tag_i[k*TAG_W +: TAG_W], wb_en_i, wb_tag_i, wb_data_i);
      if (!in_src_valid_i[k] && hit[DATA_W]) begin
        in_vld[k]                   = 1'b1;
        in_data[k*DATA_W +: DATA_W] = hit[DATA_W-1:0];
      end
    end
  end

`ifdef RS_OLDEST_FIRST_EN
  // age_q[i][j] = 1 means entry i was dispatched before entry j.
  logic [N_LINE-1:0] age_q [N_LINE];
  logic [N_LINE-1:0] age_d [N_LINE];

  always_comb begin
    logic older;
    sel_idx = '0;
    older   = 1'b1;
    for (int i = 0; i < int'(N_LINE); i++) begin
      if (ready[i]) begin
        older = 1'b1;
        for (int j = 0; j < int'(N_LINE); j++) begin
          if ((j != i) && ready[j] && !age_q[i][j]) older = 1'b0;
        end
        if (older) sel_idx = IdxW'(i);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < int'(N_LINE); i++) age_d[i] = age_q[i];
    if (accept) begin
      for (int j = 0; j < int'(N_LINE); j++) age_d[j][alloc_idx] = 1'b1;
      age_d[alloc_idx] = '0;
    end
    if (fire) begin
      for (int j = 0; j < int'(N_LINE); j++) age_d[j][sel_idx] = 1'b0;
      age_d[sel_idx] = '0;
    end
    if (flash_i) begin
      for (int i = 0; i < int'(N_LINE); i++) age_d[i] = '0;
    end
  end

  always_ff @(posedge clock_i) begin
    for (int i = 0; i < int'(N_LINE); i++) begin
      if (!reset_n_i) age_q[i] <= '0;
      else            age_q[i] <= age_d[i];
    end
  end
`else
  always_comb begin
    sel_idx = '0;
    for (int i = int'(N_LINE) - 1; i >= 0; i--) begin
      if (ready[i]) sel_idx = IdxW'(i);
    end
  end
`endif

  always_comb begin
    logic [DATA_W:0] hit;
    occ_d = occ_q;
    hit   = '0;
    for (int i = 0; i < int'(N_LINE); i++) begin
      vld_d[i]  = vld_q[i];
      tag_d[i]  = tag_q[i];
      data_d[i] = data_q[i];
      pl_d[i]   = pl_q[i];
      for (int k = 0; k < int'(N_SRC); k++) begin
        hit = snoop(tag_q[i][k*TAG_W +: TAG_W], wb_en_i, wb_tag_i, wb_data_i);
        if (!vld_q[i][k] && hit[DATA_W]) begin
          vld_d[i][k]                   = 1'b1;
          data_d[i][k*DATA_W +: DATA_W] = hit[DATA_W-1:0];
        end
      end
    end
    if (fire) occ_d[sel_idx] = 1'b0;
    if (accept) begin
      occ_d[alloc_idx]  = 1'b1;
      vld_d[alloc_idx]  = in_vld;
      tag_d[alloc_idx]  = in_src_tag_i;
      data_d[alloc_idx] = in_data;
      pl_d[alloc_idx]   = in_payload_i;
    end
    count_d = count_q + CntW'(accept) - CntW'(fire);
    if (flash_i) begin
      occ_d   = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      occ_q   <= '0;
      count_q <= '0;
    end else begin
      occ_q   <= occ_d;
      count_q <= count_d;
    end
  end

  // Entry contents need no reset: they are only observed through occupied entries.
  always_ff @(posedge clock_i) begin
    for (int i = 0; i < int'(N_LINE); i++) begin
      vld_q[i]  <= vld_d[i];
      tag_q[i]  <= tag_d[i];
      data_q[i] <= data_d[i];
      pl_q[i]   <= pl_d[i];
    end
  end

endmodule

// File: tb/tb_param_reservation_station.sv
// tb_param_reservation_station
//   Self-checking bench for param_reservation_station with default parameters.
//   Expected issues are queued at dispatch and compared when the station issues.
module tb_param_reservation_station;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flash;
  logic        in_en;
  logic        in_reject;
  logic [47:0] in_payload;
  logic [1:0]  in_src_valid;
  logic [11:0] in_src_tag;
  logic [63:0] in_src_data;
  logic [1:0]  wb_en;
  logic [11:0] wb_tag;
  logic [63:0] wb_data;
  logic        issue_en;
  logic        issue_reject;
  logic [47:0] issue_payload;
  logic [63:0] issue_src_data;
  logic [4:0]  count;

  typedef struct packed {
    logic [47:0] pl;
    logic [63:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_checks = 0;
  int   n_fail   = 0;

  param_reservation_station dut (
    .clock_i          (clk),
    .reset_n_i        (rst_n),
    .flash_i          (flash),
    .in_en_i          (in_en),
    .in_reject_o      (in_reject),
    .in_payload_i     (in_payload),
    .in_src_valid_i   (in_src_valid),
    .in_src_tag_i     (in_src_tag),
    .in_src_data_i    (in_src_data),
    .wb_en_i          (wb_en),
    .wb_tag_i         (wb_tag),
    .wb_data_i        (wb_data),
    .issue_en_o       (issue_en),
    .issue_reject_i   (issue_reject),
    .issue_payload_o  (issue_payload),
    .issue_src_data_o (issue_src_data),
    .count_o          (count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_en = 1'b0;
    wb_en = '0;
    flash = 1'b0;
  endtask

  task automatic disp(input logic [47:0] pl, input logic [1:0] v, input logic [11:0] tg,
                      input logic [63:0] d);
    in_en        = 1'b1;
    in_payload   = pl;
    in_src_valid = v;
    in_src_tag   = tg;
    in_src_data  = d;
  endtask

  task automatic wb(input int port, input logic [5:0] tag, input logic [31:0] d);
    wb_en[port]           = 1'b1;
    wb_tag[port*6 +: 6]   = tag;
    wb_data[port*32 +: 32] = d;
  endtask

  task automatic push(input logic [47:0] pl, input logic [63:0] d);
    exp_t x;
    x.pl   = pl;
    x.data = d;
    sb.push_back(x);
  endtask

  // Scoreboard: every accepted issue must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (issue_en === 1'b1 && issue_reject === 1'b0) begin
      if (sb.size() == 0) begin
        check_eq("sb_unexpected_issue", 64'(sb.size()), 64'd1);
      end else begin
        e = sb.pop_front();
        check_eq("issue_payload", 64'(issue_payload), 64'(e.pl));
        check_eq("issue_data", issue_src_data, e.data);
      end
    end
  end

  initial begin
    // T1: reset held two cycles with dispatch requested
    rst_n = 1'b0; flash = 1'b0; in_en = 1'b1; in_payload = 48'hDEAD; in_src_valid = 2'b11;
    in_src_tag = '0; in_src_data = 64'h1; wb_en = '0; wb_tag = '0; wb_data = '0;
    issue_reject = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    in_en = 1'b0;
    @(negedge clk);
    check_eq("t1_count", 64'(count), 64'd0);
    check_eq("t1_issue_en", 64'(issue_en), 64'd0);
    check_eq("t1_in_reject", 64'(in_reject), 64'd0);
    step();
    @(negedge clk);
    check_eq("t1_no_entry", 64'(issue_en), 64'd0);

    // T2: dispatch with both operands ready
    step();
    disp(48'h0A1, 2'b11, 12'h0, {32'd7, 32'd5});
    push(48'h0A1, {32'd7, 32'd5});
    step();
    idle();
    @(negedge clk);
    check_eq("t2_issue_en", 64'(issue_en), 64'd1);
    check_eq("t2_count_one", 64'(count), 64'd1);
    step();
    @(negedge clk);
    check_eq("t2_count_zero", 64'(count), 64'd0);
    check_eq("t2_issue_idle", 64'(issue_en), 64'd0);

    // T3a: wakeup two cycles after dispatch
    step();
    disp(48'h0B1, 2'b01, {6'd9, 6'd0}, {32'h0, 32'h11});
    push(48'h0B1, {32'h1234, 32'h11});
    step();
    idle();
    @(negedge clk);
    check_eq("t3_waiting", 64'(issue_en), 64'd0);
    step();
    wb(1, 6'd9, 32'h1234);
    wb(0, 6'd8, 32'hFFFF);
    @(negedge clk);
    check_eq("t3_not_comb", 64'(issue_en), 64'd0);
    step();
    idle();
    @(negedge clk);
    check_eq("t3_woken", 64'(issue_en), 64'd1);
    step();
    @(negedge clk);
    check_eq("t3_count", 64'(count), 64'd0);

    // T3b: broadcast in the dispatch cycle
    step();
    disp(48'h0B2, 2'b01, {6'd9, 6'd0}, {32'h0, 32'h22});
    wb(1, 6'd9, 32'h1234);
    push(48'h0B2, {32'h1234, 32'h22});
    step();
    idle();
    @(negedge clk);
    check_eq("t3b_snoop", 64'(issue_en), 64'd1);
    step();
    @(negedge clk);
    check_eq("t3b_count", 64'(count), 64'd0);

    // T3c: near-miss tag ignored; two matching ports, port 0 wins
    step();
    disp(48'h0B3, 2'b10, {6'd0, 6'h2A}, {32'h33, 32'h0});
    wb(0, 6'h0A, 32'hDEAD);
    push(48'h0B3, {32'h33, 32'hAAAA});
    step();
    idle();
    wb(0, 6'h2A, 32'hAAAA);
    wb(1, 6'h2A, 32'h5555);
    @(negedge clk);
    check_eq("t3c_exact_tag", 64'(issue_en), 64'd0);
    step();
    idle();
    @(negedge clk);
    check_eq("t3c_woken", 64'(issue_en), 64'd1);
    step();
    @(negedge clk);
    check_eq("t3c_count", 64'(count), 64'd0);

    // T4: fill under back-pressure, then drain
    step();
    issue_reject = 1'b1;
    for (int i = 0; i < 16; i++) begin
      disp(48'h100 + 48'(i), 2'b11, 12'h0, {32'(i + 100), 32'(i)});
      push(48'h100 + 48'(i), {32'(i + 100), 32'(i)});
      step();
    end
    disp(48'hBAD, 2'b11, 12'h0, 64'h0);
    @(negedge clk);
    check_eq("t4_full_count", 64'(count), 64'd16);
    check_eq("t4_in_reject", 64'(in_reject), 64'd1);
    step();
    issue_reject = 1'b0;
    @(negedge clk);
    check_eq("t4_reject_with_issue", 64'(in_reject), 64'd1);
    check_eq("t4_issue_en", 64'(issue_en), 64'd1);
    step();
    idle();
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      check_eq("t4_drain_count", 64'(count), 64'(15 - i));
      step();
    end
    @(negedge clk);
    check_eq("t4_empty", 64'(count), 64'd0);
    check_eq("t4_no_reject", 64'(in_reject), 64'd0);

    // T5: entry 3 older than entry 0, both become ready together
    step();
    disp(48'h5A0, 2'b10, {6'd0, 6'h30}, {32'hA1, 32'h0});
    push(48'h5A0, {32'hA1, 32'hC0});
    step();
    disp(48'h5A1, 2'b10, {6'd0, 6'h30}, {32'hA2, 32'h0});
    push(48'h5A1, {32'hA2, 32'hC0});
    step();
    disp(48'h5A2, 2'b10, {6'd0, 6'h30}, {32'hA3, 32'h0});
    push(48'h5A2, {32'hA3, 32'hC0});
    step();
    disp(48'h5D3, 2'b10, {6'd0, 6'h31}, {32'hD, 32'h0});
    step();
    idle();
    wb(0, 6'h30, 32'hC0);
    step();
    idle();
    repeat (3) step();
    @(negedge clk);
    check_eq("t5_one_left", 64'(count), 64'd1);
    check_eq("t5_d_waiting", 64'(issue_en), 64'd0);
    step();
    disp(48'h5E0, 2'b10, {6'd0, 6'h31}, {32'hE, 32'h0});
    step();
    idle();
    wb(0, 6'h31, 32'hF0);
`ifdef RS_OLDEST_FIRST_EN
    push(48'h5D3, {32'hD, 32'hF0});
    push(48'h5E0, {32'hE, 32'hF0});
`else
    push(48'h5E0, {32'hE, 32'hF0});
    push(48'h5D3, {32'hD, 32'hF0});
`endif
    step();
    idle();
    @(negedge clk);
    check_eq("t5_two_ready", 64'(count), 64'd2);
    check_eq("t5_issue_en", 64'(issue_en), 64'd1);
    step();
    @(negedge clk);
    check_eq("t5_count_one", 64'(count), 64'd1);
    step();
    @(negedge clk);
    check_eq("t5_count_zero", 64'(count), 64'd0);

    // T6: flush with five ready entries and a same-cycle dispatch
    step();
    issue_reject = 1'b1;
    for (int i = 0; i < 5; i++) begin
      disp(48'h600 + 48'(i), 2'b11, 12'h0, {32'(i), 32'(i)});
      step();
    end
    flash = 1'b1;
    disp(48'h6FF, 2'b01, {6'h3E, 6'h0}, {32'h0, 32'h1});
    issue_reject = 1'b0;
    @(negedge clk);
    check_eq("t6_flash_issue", 64'(issue_en), 64'd0);
    check_eq("t6_pre_count", 64'(count), 64'd5);
    step();
    idle();
    @(negedge clk);
    check_eq("t6_count", 64'(count), 64'd0);
    check_eq("t6_issue_en", 64'(issue_en), 64'd0);
    step();
    wb(0, 6'h3E, 32'h99);
    step();
    idle();
    @(negedge clk);
    check_eq("t6_late_wb_issue", 64'(issue_en), 64'd0);
    check_eq("t6_late_wb_count", 64'(count), 64'd0);

    step();
    check_eq("sb_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
